// File: rtl/multicycle_control_if.sv
// Control bus between the multi-cycle sequencer and the MIPS datapath.
// master = sequencer (drives strobes/selects), slave = datapath (drives IR fields, status, mem_ready).
interface multicycle_control_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic [1:0] status;
   logic       mem_ready;
   logic       pc_write;
   logic       pc_write_cond;
   logic [1:0] iord;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic [1:0] reg_dest;
   logic       reg_write;
   logic [2:0] wd_sel;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic [1:0] pc_source;

   modport master (
      input  opcode, funct, status, mem_ready,
      output pc_write, pc_write_cond, iord, mem_read, mem_write,
      output ir_write, reg_dest, reg_write, wd_sel,
      output alu_src_a, alu_src_b, alu_op, pc_source
   );

   modport slave (
      output opcode, funct, status, mem_ready,
      input  pc_write, pc_write_cond, iord, mem_read, mem_write,
      input  ir_write, reg_dest, reg_write, wd_sel,
      input  alu_src_a, alu_src_b, alu_op, pc_source
   );
endinterface

// File: rtl/multicycle_control.sv
// Moore multi-cycle sequencer for the MIPS datapath: shared memory port, ALU, regfile.
// Ports: clk_i, rst_n_i (sync, active low), bus (control interface), state_o, trap_o, retired_o.
module multicycle_control #(
   parameter int unsigned WAIT_LIMIT = 16,
   parameter int unsigned COUNT_W    = 32
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   multicycle_control_if.master bus,
   output logic [3:0]         state_o,
   output logic [1:0]         trap_o,
   output logic [COUNT_W-1:0] retired_o
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_RTYPE_EX = 4'd6,
      S_RTYPE_WB = 4'd7,
      S_BEQ      = 4'd8,
      S_BNEAL    = 4'd9,
      S_BALRN    = 4'd10,
      S_JMEM_RD  = 4'd11,
      S_JMP_MDR  = 4'd12,
      S_ORI_EX   = 4'd13,
      S_ORI_WB   = 4'd14,
      S_ILLEGAL  = 4'd15
   } state_t;

   localparam int unsigned WW =
      (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
   localparam logic [WW-1:0] LIM_M1 =
      WW'((WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1);

   state_t             state_q, state_d;
   logic [1:0]         trap_q, trap_d;
   logic [WW-1:0]      wait_q, wait_d;
   logic [COUNT_W-1:0] retired_q, retired_d;

   logic is_lw, is_sw, is_r, is_beq;
   logic is_bneal, is_jrs, is_ori;
   logic mem_st, timeout;

   assign is_lw    = bus.opcode == 6'b100011;
   assign is_sw    = bus.opcode == 6'b101011;
   assign is_r     = bus.opcode == 6'b000000;
   assign is_beq   = bus.opcode == 6'b000100;
   assign is_bneal = bus.opcode == 6'b101101;
   assign is_jrs   = bus.opcode == 6'b010010;
   assign is_ori   = bus.opcode == 6'b001101;

   assign mem_st = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                   (state_q == S_MEMWR) || (state_q == S_JMEM_RD);

   // Timeout fires on the WAIT_LIMIT-th consecutive waiting cycle;
   // a ready in that same cycle completes the access instead.
   assign timeout = mem_st && !bus.mem_ready &&
                    (WAIT_LIMIT != 0) && (wait_q == LIM_M1);

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q   <= S_FETCH;
         trap_q    <= 2'b00;
         wait_q    <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         trap_q    <= trap_d;
         wait_q    <= wait_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      trap_d    = trap_q;
      wait_d    = wait_q;
      retired_d = retired_q;
      unique case (state_q)
         S_FETCH:
            if (bus.mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            unique case (1'b1)
               is_lw, is_sw: state_d = S_MEMADR;
               is_r: begin
                  if (bus.funct == 6'b010111)
                     state_d = S_BALRN;
                  else if (bus.funct == 6'b100010)
                     state_d = S_JMEM_RD;
                  else
                     state_d = S_RTYPE_EX;
               end
               is_beq:   state_d = S_BEQ;
               is_bneal: state_d = S_BNEAL;
               is_jrs:   state_d = S_JMEM_RD;
               is_ori:   state_d = S_ORI_EX;
               default: begin
                  state_d = S_ILLEGAL;
                  trap_d  = 2'b01;
               end
            endcase
         end
         S_MEMADR:
            state_d = is_sw ? S_MEMWR : S_MEMRD;
         S_MEMRD:
            if (bus.mem_ready) state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWR:
            if (bus.mem_ready) state_d = S_FETCH;
         S_RTYPE_EX: state_d = S_RTYPE_WB;
         S_RTYPE_WB: state_d = S_FETCH;
         S_BEQ:      state_d = S_FETCH;
         S_BNEAL:    state_d = S_FETCH;
         S_BALRN:    state_d = S_FETCH;
         S_JMEM_RD:
            if (bus.mem_ready) state_d = S_JMP_MDR;
         S_JMP_MDR:  state_d = S_FETCH;
         S_ORI_EX:   state_d = S_ORI_WB;
         S_ORI_WB:   state_d = S_FETCH;
         S_ILLEGAL:  state_d = S_ILLEGAL;
         default:    state_d = S_ILLEGAL;
      endcase

      if (timeout) begin
         state_d = S_ILLEGAL;
         trap_d  = 2'b10;
      end

      // Count only while parked in a memory state; any move clears it.
      if (mem_st && state_d == state_q)
         wait_d = wait_q + WW'(1);
      else
         wait_d = '0;

      if (state_q != S_FETCH && state_d == S_FETCH)
         retired_d = retired_q + COUNT_W'(1);
   end

   always_comb begin
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.iord          = 2'b00;
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.ir_write      = 1'b0;
      bus.reg_dest      = 2'b00;
      bus.reg_write     = 1'b0;
      bus.wd_sel        = 3'b000;
      bus.alu_src_a     = 1'b0;
      bus.alu_src_b     = 2'b00;
      bus.alu_op        = 2'b00;
      bus.pc_source     = 2'b00;
      unique case (state_q)
         S_FETCH: begin
            bus.mem_read  = 1'b1;
            bus.alu_src_b = 2'b01;
            bus.ir_write  = bus.mem_ready;
            bus.pc_write  = bus.mem_ready;
         end
         S_DECODE:
            bus.alu_src_b = 2'b11;
         S_MEMADR: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            bus.iord     = 2'b01;
            bus.mem_read = 1'b1;
         end
         S_MEMWB: begin
            bus.reg_write = 1'b1;
            bus.wd_sel    = 3'b011;
         end
         S_MEMWR: begin
            bus.iord      = 2'b01;
            bus.mem_write = 1'b1;
         end
         S_RTYPE_EX: begin
            bus.alu_src_a = 1'b1;
            bus.alu_op    = 2'b10;
         end
         S_RTYPE_WB: begin
            bus.reg_dest  = 2'b01;
            bus.reg_write = 1'b1;
            bus.wd_sel    = (bus.funct == 6'b000000) ?
                            3'b001 : 3'b000;
         end
         S_BEQ: begin
            bus.alu_src_a     = 1'b1;
            bus.alu_op        = 2'b01;
            bus.pc_write_cond = 1'b1;
            bus.pc_source     = 2'b01;
         end
         S_BNEAL: begin
            bus.alu_src_a = 1'b1;
            bus.alu_op    = 2'b01;
            if (!bus.status[1]) begin
               bus.pc_write  = 1'b1;
               bus.pc_source = 2'b01;
               bus.reg_write = 1'b1;
               bus.reg_dest  = 2'b10;
               bus.wd_sel    = 3'b100;
            end
         end
         S_BALRN: begin
            if (bus.status[0]) begin
               bus.pc_write  = 1'b1;
               bus.pc_source = 2'b10;
               bus.reg_write = 1'b1;
               bus.reg_dest  = 2'b10;
               bus.wd_sel    = 3'b100;
            end
         end
         S_JMEM_RD: begin
            bus.iord     = 2'b10;
            bus.mem_read = 1'b1;
         end
         S_JMP_MDR: begin
            bus.pc_write  = 1'b1;
            bus.pc_source = 2'b11;
            // jmsub links; jrs does not
            if (is_r) begin
               bus.reg_write = 1'b1;
               bus.reg_dest  = 2'b10;
               bus.wd_sel    = 3'b100;
            end
         end
         S_ORI_EX: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'b10;
            bus.alu_op    = 2'b11;
         end
         S_ORI_WB: begin
            bus.reg_write = 1'b1;
            bus.wd_sel    = 3'b010;
         end
         S_ILLEGAL: ;
         default: ;
      endcase

      // Hold every strobe low during reset so an aborted
      // instruction cannot write anything.
      if (!rst_n_i) begin
         bus.pc_write      = 1'b0;
         bus.pc_write_cond = 1'b0;
         bus.mem_read      = 1'b0;
         bus.mem_write     = 1'b0;
         bus.ir_write      = 1'b0;
         bus.reg_write     = 1'b0;
      end
   end

   assign state_o   = state_q;
   assign trap_o    = trap_q;
   assign retired_o = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control (WAIT_LIMIT=4, COUNT_W=8).
// Each task drives one scenario and checks outputs inline.
module tb_multicycle_control;
   logic       clk;
   logic       rst_n;
   logic [3:0] state;
   logic [1:0] trap;
   logic [7:0] retired;
   int         checks;
   int         errors;
   int         exp_ret;

   multicycle_control_if bus ();

   multicycle_control #(
      .WAIT_LIMIT (4),
      .COUNT_W    (8)
   ) dut (
      .clk_i     (clk),
      .rst_n_i   (rst_n),
      .bus       (bus),
      .state_o   (state),
      .trap_o    (trap),
      .retired_o (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [5:0] strobes();
      return {bus.pc_write, bus.pc_write_cond, bus.mem_read,
              bus.mem_write, bus.ir_write, bus.reg_write};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      bus.mem_ready = 1'b1;
      bus.opcode = 6'b100011;
      bus.funct = 6'd0;
      bus.status = 2'b00;
      step();
      step();
      #1;
      checks++;
      if (state !== 4'd0 || trap !== 2'b00 || retired !== 8'd0) begin
         errors++;
         $display("FAIL reset_state: got st=%0d trap=%0d ret=%0d want 0 0 0",
                  state, trap, retired);
      end
      checks++;
      if (strobes() !== 6'b0) begin
         errors++;
         $display("FAIL reset_strobes: got %b want 000000", strobes());
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (bus.mem_read !== 1'b1 || bus.ir_write !== 1'b1 ||
          bus.pc_write !== 1'b1 || bus.alu_src_b !== 2'b01) begin
         errors++;
         $display("FAIL fetch_ctl: got rd=%b irw=%b pcw=%b srcb=%b want 1 1 1 01",
                  bus.mem_read, bus.ir_write, bus.pc_write, bus.alu_src_b);
      end
      exp_ret = 0;
   endtask

   task automatic test_lw();
      int exp_st[6] = '{0, 1, 2, 3, 4, 0};
      bus.opcode = 6'b100011;
      bus.mem_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         checks++;
         if (state !== 4'(exp_st[i])) begin
            errors++;
            $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, exp_st[i]);
         end
         checks++;
         if (bus.reg_write !== (exp_st[i] == 4)) begin
            errors++;
            $display("FAIL lw_regwrite[%0d]: got %b", i, bus.reg_write);
         end
         if (exp_st[i] == 4) begin
            checks++;
            if (bus.wd_sel !== 3'b011 || bus.reg_dest !== 2'b00) begin
               errors++;
               $display("FAIL lw_wb: got wd=%b rd=%b want 011 00",
                        bus.wd_sel, bus.reg_dest);
            end
         end
         if (i < 5) step();
      end
      exp_ret++;
      checks++;
      if (retired !== 8'(exp_ret)) begin
         errors++;
         $display("FAIL lw_retired: got %0d want %0d", retired, exp_ret);
      end
   endtask

   task automatic test_rtype();
      logic [5:0] fn[2] = '{6'b000000, 6'b100000};
      logic [2:0] wd[2] = '{3'b001, 3'b000};
      int exp_st[4] = '{0, 1, 6, 7};
      bus.opcode = 6'b000000;
      bus.mem_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         bus.funct = fn[k];
         for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (state !== 4'(exp_st[i])) begin
               errors++;
               $display("FAIL rtype_state[%0d][%0d]: got %0d want %0d",
                        k, i, state, exp_st[i]);
            end
            if (i == 2) begin
               checks++;
               if (bus.alu_op !== 2'b10 || bus.alu_src_a !== 1'b1 ||
                   bus.alu_src_b !== 2'b00) begin
                  errors++;
                  $display("FAIL rtype_ex[%0d]: got op=%b a=%b b=%b",
                           k, bus.alu_op, bus.alu_src_a, bus.alu_src_b);
               end
            end
            if (i == 3) begin
               checks++;
               if (bus.wd_sel !== wd[k] || bus.reg_dest !== 2'b01 ||
                   bus.reg_write !== 1'b1) begin
                  errors++;
                  $display("FAIL rtype_wb[%0d]: got wd=%b rd=%b rw=%b want %b 01 1",
                           k, bus.wd_sel, bus.reg_dest, bus.reg_write, wd[k]);
               end
            end
            step();
         end
         exp_ret++;
      end
      #1;
      checks++;
      if (state !== 4'd0 || retired !== 8'(exp_ret)) begin
         errors++;
         $display("FAIL rtype_retired: got st=%0d ret=%0d want 0 %0d",
                  state, retired, exp_ret);
      end
   endtask

   task automatic test_bneal();
      logic [1:0] st[2] = '{2'b00, 2'b10};
      logic       tk[2] = '{1'b1, 1'b0};
      bus.opcode = 6'b101101;
      bus.mem_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         bus.status = st[k];
         step();
         step();
         #1;
         checks++;
         if (state !== 4'd9) begin
            errors++;
            $display("FAIL bneal_state[%0d]: got %0d want 9", k, state);
         end
         checks++;
         if (bus.pc_write !== tk[k] || bus.reg_write !== tk[k]) begin
            errors++;
            $display("FAIL bneal_take[%0d]: got pcw=%b rw=%b want %b",
                     k, bus.pc_write, bus.reg_write, tk[k]);
         end
         if (tk[k]) begin
            checks++;
            if (bus.reg_dest !== 2'b10 || bus.wd_sel !== 3'b100 ||
                bus.pc_source !== 2'b01) begin
               errors++;
               $display("FAIL bneal_link: got rd=%b wd=%b ps=%b want 10 100 01",
                        bus.reg_dest, bus.wd_sel, bus.pc_source);
            end
         end
         step();
         exp_ret++;
      end
      bus.status = 2'b00;
   endtask

   task automatic test_jmem();
      logic [5:0] op[2] = '{6'b000000, 6'b010010};
      logic       lk[2] = '{1'b1, 1'b0};
      for (int k = 0; k < 2; k++) begin
         bus.opcode = op[k];
         bus.funct = 6'b100010;
         bus.mem_ready = 1'b1;
         step();
         step();
         for (int c = 0; c < 4; c++) begin
            bus.mem_ready = (k == 0) ? (c == 3) : 1'b1;
            #1;
            checks++;
            if (state !== 4'd11 || bus.iord !== 2'b10 ||
                bus.mem_read !== 1'b1) begin
               errors++;
               $display("FAIL jmem_rd[%0d][%0d]: got st=%0d iord=%b rd=%b",
                        k, c, state, bus.iord, bus.mem_read);
            end
            step();
            if (k == 1) break;
         end
         #1;
         checks++;
         if (state !== 4'd12 || bus.pc_write !== 1'b1 ||
             bus.pc_source !== 2'b11) begin
            errors++;
            $display("FAIL jmp_mdr[%0d]: got st=%0d pcw=%b ps=%b want 12 1 11",
                     k, state, bus.pc_write, bus.pc_source);
         end
         checks++;
         if (bus.reg_write !== lk[k] ||
             (lk[k] && bus.reg_dest !== 2'b10)) begin
            errors++;
            $display("FAIL jmp_link[%0d]: got rw=%b rd=%b want %b",
                     k, bus.reg_write, bus.reg_dest, lk[k]);
         end
         step();
         exp_ret++;
      end
      #1;
      checks++;
      if (state !== 4'd0 || retired !== 8'(exp_ret) || trap !== 2'b00) begin
         errors++;
         $display("FAIL jmem_end: got st=%0d ret=%0d trap=%0d want 0 %0d 0",
                  state, retired, trap, exp_ret);
      end
   endtask

   task automatic test_illegal();
      bus.opcode = 6'b111111;
      bus.mem_ready = 1'b1;
      step();
      step();
      #1;
      checks++;
      if (state !== 4'd15 || trap !== 2'b01) begin
         errors++;
         $display("FAIL illegal_entry: got st=%0d trap=%0d want 15 1",
                  state, trap);
      end
      for (int c = 0; c < 20; c++) begin
         bus.mem_ready = c[0];
         bus.status = c[1:0];
         bus.opcode = (c[2]) ? 6'b100011 : 6'b000000;
         step();
         checks++;
         if (state !== 4'd15 || trap !== 2'b01 || strobes() !== 6'b0 ||
             retired !== 8'(exp_ret)) begin
            errors++;
            $display("FAIL illegal_hold[%0d]: got st=%0d trap=%0d stb=%b ret=%0d",
                     c, state, trap, strobes(), retired);
         end
      end
   endtask

   task automatic test_timeout();
      rst_n = 1'b0;
      bus.mem_ready = 1'b0;
      step();
      rst_n = 1'b1;
      exp_ret = 0;
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++;
         if (state !== 4'd0 || trap !== 2'b00) begin
            errors++;
            $display("FAIL tmo_wait[%0d]: got st=%0d trap=%0d want 0 0",
                     c, state, trap);
         end
         step();
      end
      checks++;
      if (state !== 4'd15 || trap !== 2'b10 || strobes() !== 6'b0) begin
         errors++;
         $display("FAIL tmo_trap: got st=%0d trap=%0d stb=%b want 15 2 0",
                  state, trap, strobes());
      end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      #1;
      checks++;
      if (state !== 4'd0 || trap !== 2'b00 || retired !== 8'd0) begin
         errors++;
         $display("FAIL tmo_reset: got st=%0d trap=%0d ret=%0d want 0 0 0",
                  state, trap, retired);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      exp_ret = 0;
      rst_n = 1'b0;
      bus.opcode = 6'd0;
      bus.funct = 6'd0;
      bus.status = 2'b00;
      bus.mem_ready = 1'b0;
      test_reset();
      test_lw();
      test_rtype();
      test_bneal();
      test_jmem();
      test_illegal();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle sequencer for the MIPS datapath, replacing single-cycle decode with a Moore FSM that drives one shared memory port, ALU and register file over several cycles per instruction.
Supports R-type (incl. sll, balrn, jmsub), lw, sw, beq, bneal, jrs and ori.
Stretches memory states on a ready handshake and traps on unknown opcodes or memory timeout.
Counts retired instructions.

Parameters:
WAIT_LIMIT, 16, max cycles any memory state waits for mem_ready before bus-error trap; 0 disables timeout
COUNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
opcode  in  6  IR[31:26], stable from DECODE until next FETCH
funct  in  6  IR[5:0]
status  in  2  [1]=ALU zero, [0]=ALU negative (combinational from current ALU op)
mem_ready  in  1  memory completes access this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load gated by zero in datapath (beq)
iord  out  2  memory address: 00 PC, 01 ALUOut, 10 regA
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  IR load
reg_dest  out  2  00 rt, 01 rd, 10 r31
reg_write  out  1  register-file write
wd_sel  out  3  000 ALUOut, 001 shifter, 010 ORI result, 011 MDR, 100 PC (link)
alu_src_a  out  1  0 PC, 1 regA
alu_src_b  out  2  00 regB, 01 const 4, 10 sign-ext imm, 11 imm<<2
alu_op  out  2  00 add, 01 sub, 10 funct, 11 or
pc_source  out  2  00 ALU result, 01 ALUOut, 10 regA, 11 MDR
state  out  4  current state code
trap  out  2  00 none, 01 illegal opcode, 10 memory timeout
retired  out  COUNT_W  instructions completed

Behaviour:
- Reset (rst_n=0 at clk edge): state=FETCH, trap=00, retired=0, wait counter=0. All strobes read 0 while rst_n=0. Reset mid-instruction aborts it; no partial writes occur.
- Outputs are decoded from state only, except gating by mem_ready and status noted below. Unlisted outputs are 0.
- FETCH(0): iord=00, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write and pc_write=mem_ready. Go to DECODE on mem_ready, else hold.
- DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state:
  - lw 100011 / sw 101011 -> MEMADR
  - opcode 000000 -> RTYPE_EX, except funct 010111 (balrn) -> BALRN and 100010 (jmsub) -> JMEM_RD
  - beq 000100 -> BEQ
  - bneal 101101 -> BNEAL
  - jrs 010010 -> JMEM_RD
  - ori 001101 -> ORI_EX
  - else ILLEGAL
- MEMADR(2): alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEMRD (lw) or MEMWR (sw).
- MEMRD(3): iord=01, mem_read=1. Go to MEMWB on mem_ready.
- MEMWB(4): reg_dest=00, reg_write=1, wd_sel=011. Go to FETCH.
- MEMWR(5): iord=01, mem_write=1. Go to FETCH on mem_ready.
- RTYPE_EX(6): alu_src_a=1, alu_src_b=00, alu_op=10. Go to RTYPE_WB.
- RTYPE_WB(7): reg_dest=01, reg_write=1, wd_sel=001 if funct=000000 else 000. Go to FETCH.
- BEQ(8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Go to FETCH.
- BNEAL(9): operands/alu_op as BEQ. If status[1]=0: pc_write=1, pc_source=01, reg_write=1, reg_dest=10, wd_sel=100. Go to FETCH.
- BALRN(10): if status[0]=1: pc_write=1, pc_source=10, reg_write=1, reg_dest=10, wd_sel=100. Go to FETCH.
- JMEM_RD(11): iord=10, mem_read=1. MDR captures on mem_ready. Go to JMP_MDR.
- JMP_MDR(12): pc_write=1, pc_source=11. If opcode=000000 (jmsub), also reg_write=1, reg_dest=10, wd_sel=100 (link from PC+4). Go to FETCH.
- ORI_EX(13): alu_src_a=1, alu_src_b=10, alu_op=11. Go to ORI_WB.
- ORI_WB(14): reg_dest=00, reg_write=1, wd_sel=010. Go to FETCH.
- ILLEGAL(15): all strobes 0. Sticky until reset. trap=01 set on entry, or 10 if entered via timeout.
- Wait counter clears on entry to each memory state (FETCH, MEMRD, MEMWR, JMEM_RD) and increments each cycle mem_ready=0. If WAIT_LIMIT!=0 and the count reaches WAIT_LIMIT with mem_ready still 0, go to ILLEGAL with trap=10. mem_ready=1 in the same cycle wins over timeout.
- retired increments by 1 on every transition into FETCH from a non-FETCH state; it wraps modulo 2^COUNT_W.
- mem_ready asserted in the first memory cycle: zero wait, one cycle in state.

Test Plan:
- Reset then lw with mem_ready=1 always -> states 0,1,2,3,4,0; reg_write only in MEMWB with wd_sel=011, reg_dest=00; retired=1.
- sll (op 0, funct 0), then add (funct 100000) -> RTYPE_WB wd_sel=001 then 000, reg_dest=01; retired=2.
- bneal with status[1]=0 -> BNEAL asserts pc_write, reg_write, reg_dest=10, wd_sel=100. Repeat with status[1]=1 -> no pc_write/reg_write.
- jmsub (funct 100010) with mem_ready held 0 for 3 cycles in JMEM_RD -> stays in 11 for 4 cycles, then JMP_MDR asserts pc_write, pc_source=11, reg_write, reg_dest=10. jrs -> same path without reg_write.
- WAIT_LIMIT=4, mem_ready=0 forever in FETCH -> after 4 waiting cycles state=15, trap=10, all strobes 0. Pulsing rst_n low one cycle -> state=0, trap=00, retired=0.
- opcode 111111 -> DECODE to ILLEGAL, trap=01, held for 20 cycles regardless of inputs.
